// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: 2-entry skid buffer that feeds the ALU with operand forwarding from MEM/WB.
// Optional macro ISSUE_BYPASS_EN enables capture forwarding and snooping of held entries.
module alu_issue_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [FUNC_W-1:0] id_alu_func,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [WIDTH-1:0]  id_op1,
  input  logic [WIDTH-1:0]  id_op2,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [WIDTH-1:0]  alu_op1,
  output logic [WIDTH-1:0]  alu_op2,
  output logic [FUNC_W-1:0] alu_func,
  output logic [REG_AW-1:0] ex_rd_addr
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
  } entry_t;

  state_t r_state;
  entry_t r_head;
  entry_t r_skid;

  entry_t w_raw;
  entry_t w_cap;
  entry_t w_head_snp;
  entry_t w_skid_snp;
  logic   w_in;
  logic   w_out;

  assign id_ready   = (r_state != FULL);
  assign ex_valid   = (r_state != EMPTY);
  assign alu_op1    = r_head.op1;
  assign alu_op2    = r_head.op2;
  assign alu_func   = r_head.func;
  assign ex_rd_addr = r_head.rd;

  assign w_in  = id_valid & id_ready;
  assign w_out = ex_valid & ex_ready;

  assign w_raw = '{func: id_alu_func, rd: id_rd_addr, rs1: id_rs1_addr,
                   rs2: id_rs2_addr, op1: id_op1, op2: id_op2};

`ifdef ISSUE_BYPASS_EN
  // MEM is the younger result, so it wins over WB; x0 is hardwired and never forwarded.
  function automatic logic [WIDTH-1:0] fwd(input logic [REG_AW-1:0] rs,
                                           input logic [WIDTH-1:0]  cur);
    if (rs == '0)               return cur;
    else if (rs == mem_rd_addr) return mem_data;
    else if (rs == wb_rd_addr)  return wb_data;
    else                        return cur;
  endfunction

  function automatic entry_t snoop(input entry_t e);
    entry_t s;
    s     = e;
    s.op1 = fwd(e.rs1, e.op1);
    s.op2 = fwd(e.rs2, e.op2);
    return s;
  endfunction

  // Capture-time forwarding is the same rule as snooping, applied to the incoming op.
  assign w_cap      = snoop(w_raw);
  assign w_head_snp = snoop(r_head);
  assign w_skid_snp = snoop(r_skid);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{mem_rd_addr, mem_data, wb_rd_addr, wb_data, r_head.rs1, r_head.rs2};
  assign w_cap        = w_raw;
  assign w_head_snp   = r_head;
  assign w_skid_snp   = r_skid;
`endif

  // NOTE: data registers are reset too, because alu_* must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in) begin
            r_state <= BUSY;
            r_head  <= w_cap;
          end
        end
        BUSY: begin
          if (w_in && !w_out) begin
            r_state <= FULL;
            r_head  <= w_head_snp;
            r_skid  <= w_cap;
          end else if (w_in && w_out) begin
            r_head <= w_cap;
          end else if (w_out) begin
            r_state <= EMPTY;
          end else begin
            r_head <= w_head_snp;
          end
        end
        FULL: begin
          // The skid entry is still in flight when it moves up, so it keeps snooping.
          if (w_out) begin
            r_state <= BUSY;
            r_head  <= w_skid_snp;
          end else begin
            r_head <= w_head_snp;
            r_skid <= w_skid_snp;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized traffic
// against a queue-based reference model of the two-entry stage.
module tb_alu_issue_stage;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
  localparam int FUNC_W = 4;

`ifdef ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [FUNC_W-1:0] func;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [FUNC_W-1:0] id_alu_func;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [WIDTH-1:0]  id_op1;
  logic [WIDTH-1:0]  id_op2;
  logic [REG_AW-1:0] id_rd_addr;
  logic [REG_AW-1:0] mem_rd_addr;
  logic [WIDTH-1:0]  mem_data;
  logic [REG_AW-1:0] wb_rd_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [WIDTH-1:0]  alu_op1;
  logic [WIDTH-1:0]  alu_op2;
  logic [FUNC_W-1:0] alu_func;
  logic [REG_AW-1:0] ex_rd_addr;

  int  n_checks   = 0;
  int  n_failures = 0;
  op_t q[$];

  alu_issue_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .FUNC_W(FUNC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_alu_func(id_alu_func),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_op1(id_op1), .id_op2(id_op2), .id_rd_addr(id_rd_addr),
    .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func), .ex_rd_addr(ex_rd_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] fwd_val(input logic [REG_AW-1:0] rs,
                                               input logic [WIDTH-1:0] cur);
    if (!BYP || rs == 0)    return cur;
    if (rs == mem_rd_addr)  return mem_data;
    if (rs == wb_rd_addr)   return wb_data;
    return cur;
  endfunction

  // Model: advance the queue for the coming edge, then compare after the edge.
  task automatic step();
    bit  xin, xout;
    op_t n;
    xout = (q.size() > 0) && ex_ready;
    xin  = id_valid && (q.size() < 2);
    if (flush) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      foreach (q[i]) begin
        q[i].op1 = fwd_val(q[i].rs1, q[i].op1);
        q[i].op2 = fwd_val(q[i].rs2, q[i].op2);
      end
      if (xin) begin
        n.func = id_alu_func; n.rd = id_rd_addr;
        n.rs1  = id_rs1_addr; n.rs2 = id_rs2_addr;
        n.op1  = fwd_val(id_rs1_addr, id_op1);
        n.op2  = fwd_val(id_rs2_addr, id_op2);
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
    check("ex_valid", 64'(ex_valid), 64'(q.size() > 0));
    check("id_ready", 64'(id_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("alu_op1", 64'(alu_op1), 64'(q[0].op1));
      check("alu_op2", 64'(alu_op2), 64'(q[0].op2));
      check("alu_func", 64'(alu_func), 64'(q[0].func));
      check("ex_rd_addr", 64'(ex_rd_addr), 64'(q[0].rd));
    end
  endtask

  task automatic drive_op(input logic v, input logic [FUNC_W-1:0] f,
                          input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                          input logic [WIDTH-1:0] o1, input logic [WIDTH-1:0] o2,
                          input logic [REG_AW-1:0] rd);
    id_valid = v; id_alu_func = f; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_op1 = o1; id_op2 = o2; id_rd_addr = rd;
  endtask

  task automatic drive_fwd(input logic [REG_AW-1:0] mrd, input logic [WIDTH-1:0] md,
                           input logic [REG_AW-1:0] wrd, input logic [WIDTH-1:0] wd);
    mem_rd_addr = mrd; mem_data = md; wb_rd_addr = wrd; wb_data = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_id_ready"}, 64'(id_ready), 64'd1);
    check({tag, "_alu_op1"}, 64'(alu_op1), 64'd0);
    check({tag, "_alu_op2"}, 64'(alu_op2), 64'd0);
    check({tag, "_alu_func"}, 64'(alu_func), 64'd0);
    check({tag, "_rd"}, 64'(ex_rd_addr), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive_op(0, 0, 0, 0, 0, 0, 0);
    drive_fwd(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic issue with one-cycle latency.
    ex_ready = 1'b1;
    drive_op(1, 4'd1, 0, 0, 32'd1, 32'd2, 5'd3);
    step();
    check("basic_op1", 64'(alu_op1), 64'd1);
    check("basic_op2", 64'(alu_op2), 64'd2);
    check("basic_func", 64'(alu_func), 64'd1);
    check("basic_rd", 64'(ex_rd_addr), 64'd3);
    check("basic_ready", 64'(id_ready), 64'd1);
    drive_op(0, 0, 0, 0, 0, 0, 0);
    step();

    // Fill to FULL, then drain.
    ex_ready = 1'b0;
    drive_op(1, 4'd2, 0, 0, 32'd10, 32'd11, 5'd4);
    step();
    drive_op(1, 4'd3, 0, 0, 32'd20, 32'd21, 5'd5);
    step();
    check("full_ready", 64'(id_ready), 64'd0);
    check("full_head", 64'(alu_op1), 64'd10);
    drive_op(0, 0, 0, 0, 0, 0, 0);
    ex_ready = 1'b1;
    step();
    check("drain_head", 64'(alu_op1), 64'd20);
    check("drain_ready", 64'(id_ready), 64'd1);
    step();

    // Capture-time forwarding priorities.
    drive_fwd(5'd5, 32'hAAAA, 5'd5, 32'hBBBB);
    drive_op(1, 4'd4, 5'd5, 0, 32'h11, 32'h22, 5'd6);
    step();
    check("fwd_mem", 64'(alu_op1), BYP ? 64'hAAAA : 64'h11);
    drive_fwd(5'd6, 32'hAAAA, 5'd5, 32'hBBBB);
    step();
    check("fwd_wb", 64'(alu_op1), BYP ? 64'hBBBB : 64'h11);
    drive_fwd(5'd0, 32'hAAAA, 5'd0, 32'hBBBB);
    drive_op(1, 4'd4, 5'd0, 0, 32'h33, 32'h22, 5'd6);
    step();
    check("fwd_x0", 64'(alu_op1), 64'h33);
    drive_op(0, 0, 0, 0, 0, 0, 0);
    step();

    // Snoop while the head is stalled.
    ex_ready = 1'b0;
    drive_op(1, 4'd5, 0, 5'd7, 32'h1, 32'h55, 5'd8);
    step();
    drive_op(0, 0, 0, 0, 0, 0, 0);
    drive_fwd(0, 0, 5'd7, 32'h1234);
    step();
    check("snoop_op2", 64'(alu_op2), BYP ? 64'h1234 : 64'h55);
    drive_fwd(0, 0, 0, 0);
    ex_ready = 1'b1;
    step();

    // Flush from FULL discards held and incoming ops.
    ex_ready = 1'b0;
    drive_op(1, 4'd6, 0, 0, 32'h60, 32'h61, 5'd9);
    step();
    step();
    flush = 1'b1;
    step();
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_ready", 64'(id_ready), 64'd1);
    flush = 1'b0;
    drive_op(0, 0, 0, 0, 0, 0, 0);
    ex_ready = 1'b1;
    step();
    check("flush_nothing", 64'(ex_valid), 64'd0);

    // Asynchronous reset in the middle of a cycle while FULL.
    ex_ready = 1'b0;
    drive_op(1, 4'd7, 0, 0, 32'h70, 32'h71, 5'd10);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    #2;
    rst_n = 1'b1;
    drive_op(0, 0, 0, 0, 0, 0, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive_op($urandom_range(0, 3) != 0, FUNC_W'($urandom), REG_AW'($urandom_range(0, 3)),
               REG_AW'($urandom_range(0, 3)), $urandom, $urandom, REG_AW'($urandom));
      drive_fwd(REG_AW'($urandom_range(0, 3)), $urandom, REG_AW'($urandom_range(0, 3)), $urandom);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
